// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_pkg;

    typedef enum logic [2:0] {
        LEN  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } load_state_e;

    localparam logic [7:0] NOP_CODE = 8'h80;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_NOP = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    // Running image checksum: plain byte sum, wrapping at 8 bits.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/loader_ram.sv
// Instruction RAM: synchronous write port from the loader, asynchronous read port for fetch.
module loader_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [DEPTH];

    // Byte write from the loader while an image streams in.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/imem_prog_loader.sv
// Loads a framed, checksummed program image into instruction RAM and
// releases the core from reset only once the image is verified.
module imem_prog_loader
    import imem_pkg::*;
#(
    parameter int         DEPTH    = 64,
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] NOP_CODE = imem_pkg::NOP_CODE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              reload,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [7:0]        fetch_data,
    output logic              cpu_reset_n,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] loaded_len
);

    localparam int         RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

    load_state_e       state_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        sum_r;
    logic              cpu_reset_n_r;
    logic              load_done_r;
    logic              load_err_r;
    logic [ADDR_W-1:0] loaded_len_r;

    logic              ram_we_s;
    logic [7:0]        ram_rdata_s;
    logic              fetch_hit_s;

    // Byte acceptance depends only on state; RUN and ERR refuse all traffic.
    always_comb begin
        s_ready = 1'b0;
        case (state_r)
            LEN, DATA, CSUM: s_ready = 1'b1;
            RUN, ERR:        s_ready = 1'b0;
            default:         s_ready = 1'b0;
        endcase
    end

    // A reload in the same cycle drops the byte, so it must also block the RAM write.
    assign ram_we_s = (state_r == DATA) && s_valid && !reload;

    // Loader FSM with its registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= LEN;
            len_r         <= {ADDR_W{1'b0}};
            addr_r        <= {ADDR_W{1'b0}};
            sum_r         <= 8'h00;
            cpu_reset_n_r <= 1'b0;
            load_done_r   <= 1'b0;
            load_err_r    <= 1'b0;
            loaded_len_r  <= {ADDR_W{1'b0}};
        end else if (reload) begin
            state_r       <= LEN;
            addr_r        <= {ADDR_W{1'b0}};
            sum_r         <= 8'h00;
            cpu_reset_n_r <= 1'b0;
            load_done_r   <= 1'b0;
            load_err_r    <= 1'b0;
            loaded_len_r  <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                LEN: begin
                    if (s_valid) begin
                        if ((s_data == 8'h00) || ({1'b0, s_data} > DEPTH_9)) begin
                            state_r    <= ERR;
                            load_err_r <= 1'b1;
                        end else begin
                            len_r   <= ADDR_W'(s_data);
                            addr_r  <= {ADDR_W{1'b0}};
                            sum_r   <= 8'h00;
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (s_valid) begin
                        sum_r  <= csum_add(sum_r, s_data);
                        addr_r <= addr_r + ADDR_W'(1);
                        if ((addr_r + ADDR_W'(1)) == len_r) begin
                            state_r <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (s_valid) begin
                        if (s_data == sum_r) begin
                            state_r       <= RUN;
                            loaded_len_r  <= len_r;
                            cpu_reset_n_r <= 1'b1;
                            load_done_r   <= 1'b1;
                        end else begin
                            state_r    <= ERR;
                            load_err_r <= 1'b1;
                        end
                    end
                end
                RUN, ERR: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r       <= LEN;
                    cpu_reset_n_r <= 1'b0;
                    load_done_r   <= 1'b0;
                    load_err_r    <= 1'b0;
                end
            endcase
        end
    end

    loader_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (addr_r[RAM_AW-1:0]),
        .wdata (s_data),
        .raddr (fetch_addr[RAM_AW-1:0]),
        .rdata (ram_rdata_s)
    );

    // Only bytes of the current verified image are visible; stale RAM reads as nop.
    assign fetch_hit_s = (state_r == RUN) && (fetch_addr < loaded_len_r);

    always_comb begin
        fetch_data = NOP_CODE;
        if (fetch_hit_s) begin
            fetch_data = ram_rdata_s;
        end else begin
            fetch_data = NOP_CODE;
        end
    end

    assign cpu_reset_n = cpu_reset_n_r;
    assign load_done   = load_done_r;
    assign load_err    = load_err_r;
    assign loaded_len  = loaded_len_r;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed self-checking bench for imem_prog_loader.
module tb_imem_prog_loader;

    logic       clk;
    logic       reset;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       reload;
    logic [7:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       cpu_reset_n;
    logic       load_done;
    logic       load_err;
    logic [7:0] loaded_len;

    int vecs = 0;
    int errs = 0;

    logic [7:0] nom [8] = '{8'h06, 8'h0A, 8'h49, 8'h11, 8'hC1, 8'h53, 8'h32, 8'hAA};

    imem_prog_loader #(.DEPTH(64), .ADDR_W(8), .NOP_CODE(8'h80)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .reload      (reload),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .cpu_reset_n (cpu_reset_n),
        .load_done   (load_done),
        .load_err    (load_err),
        .loaded_len  (loaded_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one byte for exactly one clock edge; returns 1 ns after the edge.
    task automatic send_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic chk_fetch(input logic [7:0] a, input logic [7:0] exp, input string name);
        fetch_addr = a;
        #1;
        vecs++;
        if (fetch_data !== exp) begin
            errs++;
            $display("FAIL %s: fetch[%0d] got %h expected %h", name, a, fetch_data, exp);
        end
    endtask

    task automatic chk_status(input logic rdy, input logic crn, input logic dn, input logic er,
                              input logic [7:0] len, input string name);
        vecs++;
        if ({s_ready, cpu_reset_n, load_done, load_err, loaded_len} !== {rdy, crn, dn, er, len}) begin
            errs++;
            $display("FAIL %s: rdy/crn/done/err/len got %b%b%b%b/%0d expected %b%b%b%b/%0d", name,
                     s_ready, cpu_reset_n, load_done, load_err, loaded_len, rdy, crn, dn, er, len);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(2);
        chk_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "reset_state");
        chk_fetch(8'd0, 8'h80, "reset_fetch");
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_nominal();
        for (int i = 0; i < 7; i++) send_byte(nom[i]);
        chk_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "nominal_before_csum");
        send_byte(nom[7]);
        chk_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd6, "nominal_run");
        chk_fetch(8'd3, 8'hC1, "nominal_a3");
        chk_fetch(8'd5, 8'h32, "nominal_a5");
        chk_fetch(8'd6, 8'h80, "nominal_a6");
        chk_fetch(8'd0, 8'h0A, "nominal_a0");
    endtask

    task automatic test_reload_shorter();
        pulse_reload();
        chk_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "reload_cleared");
        chk_fetch(8'd3, 8'h80, "reload_fetch_nop");
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h09);
        chk_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "short_before_csum");
        send_byte(8'h09);
        chk_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, "short_run");
        chk_fetch(8'd0, 8'h00, "short_a0");
        chk_fetch(8'd1, 8'h09, "short_a1");
        chk_fetch(8'd2, 8'h80, "short_a2_stale_hidden");
        chk_fetch(8'd3, 8'h80, "short_a3_stale_hidden");
    endtask

    task automatic test_bad_csum();
        pulse_reload();
        for (int i = 0; i < 7; i++) send_byte(nom[i]);
        send_byte(8'hAB);
        chk_status(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "badcsum_err");
        chk_fetch(8'd3, 8'h80, "badcsum_a3");
        chk_fetch(8'd0, 8'h80, "badcsum_a0");
        send_byte(8'h06);
        chk_status(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "badcsum_no_accept");
        pulse_reload();
        chk_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "badcsum_reload");
    endtask

    task automatic test_len_bounds();
        send_byte(8'h00);
        chk_status(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "len_zero_err");
        pulse_reload();
        send_byte(8'h41);
        chk_status(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "len_65_err");
        pulse_reload();
        send_byte(8'h40);
        for (int i = 0; i < 64; i++) send_byte(8'h00);
        chk_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "len_64_in_csum");
        send_byte(8'h00);
        chk_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd64, "len_64_run");
        chk_fetch(8'd63, 8'h00, "len_64_a63");
        chk_fetch(8'd64, 8'h80, "len_64_a64");
        chk_fetch(8'd255, 8'h80, "len_64_a255");
    endtask

    task automatic test_gaps();
        pulse_reload();
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 3));
            send_byte(nom[i]);
        end
        chk_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd6, "gaps_run");
        for (int i = 0; i < 6; i++) chk_fetch(8'(i), nom[i+1], "gaps_ram");
        s_valid = 1'b1;
        s_data  = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd6, "gaps_extra_refused");
        chk_fetch(8'd1, 8'h49, "gaps_after_extra");
    endtask

    task automatic test_reload_midload();
        pulse_reload();
        send_byte(8'h06);
        send_byte(8'h0A);
        s_valid = 1'b1;
        s_data  = 8'h03;
        pulse_reload();
        s_valid = 1'b0;
        chk_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "midreload_len");
        for (int i = 0; i < 8; i++) send_byte(nom[i]);
        chk_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd6, "midreload_run");
        chk_fetch(8'd4, 8'h53, "midreload_a4");
    endtask

    task automatic test_reset_midload();
        pulse_reload();
        send_byte(8'h06);
        send_byte(8'h0A);
        send_byte(8'h49);
        #2;
        reset = 1'b0;
        #1;
        chk_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "midreset_state");
        chk_fetch(8'd0, 8'h80, "midreset_fetch");
        idle(1);
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) send_byte(nom[i]);
        chk_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd6, "midreset_then_run");
        chk_fetch(8'd5, 8'h32, "midreset_a5");
    endtask

    initial begin
        reset      = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        reload     = 1'b0;
        fetch_addr = 8'h00;
        #2;
        test_reset();
        test_nominal();
        test_reload_shorter();
        test_bad_csum();
        test_len_bounds();
        test_gaps();
        test_reload_midload();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
